mem_access_unit: RTL and testbench

- Load/store unit sitting between the MEM stage of the 5-stage MIPS pipeline and a variable-latency data memory.
- Consumes the MEM-stage address and store data (aluoutM, writedataM) plus a memory-op code.
- Drives a req/ready memory handshake, aligns and extends load data into readdataM, and stalls the pipeline while an access is outstanding.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory handshake bundle: the unit drives the request side (master),
// the memory answers with read data and a one-cycle ready (slave).
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one req/ready access per instruction,
// stalls the pipeline while it is outstanding and aligns/extends load data.
//
// state  | meaning
// S_IDLE | no access in flight; an aligned memenM op is latched and issued
// S_WAIT | request held on the bus, counting cycles until ready or timeout
// S_DONE | result registered; pipeline released for one cycle
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memenM,
  input  logic [2:0]          memopM,
  input  logic [31:0]         aluoutM,
  input  logic [31:0]         writedataM,
  output logic [31:0]         readdataM,
  output logic                stallM,
  output logic                adelM,
  output logic                adesM,
  output logic                buserrM,
  mem_access_unit_if.master   mem
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [2:0]       opLat;
  logic [1:0]       offLat;

  logic        isStore, isHalf, isWord, misaligned, accept, timeoutHit;
  logic [3:0]  storeStrb;
  logic [31:0] storeData, loadExt;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign isStore    = (memopM == OP_SW) || (memopM == OP_SH) || (memopM == OP_SB);
  assign isHalf     = (memopM == OP_LH) || (memopM == OP_LHU) || (memopM == OP_SH);
  assign isWord     = (memopM == OP_LW) || (memopM == OP_SW);
  assign misaligned = (isHalf && aluoutM[0]) || (isWord && (aluoutM[1:0] != 2'b00));
  assign accept     = (state == S_IDLE) && memenM && !misaligned;
  assign timeoutHit = (state == S_WAIT) && !mem.mem_ready &&
                      (waitCnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    storeStrb = 4'b0000;
    storeData = 32'h0;
    case (memopM)
      OP_SB: begin
        storeStrb = 4'b0001 << aluoutM[1:0];
        storeData = {4{writedataM[7:0]}};
      end
      OP_SH: begin
        storeStrb = 4'b0011 << aluoutM[1:0];
        storeData = {2{writedataM[15:0]}};
      end
      OP_SW: begin
        storeStrb = 4'b1111;
        storeData = writedataM;
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched byte offset; mem_addr has it cleared.
  always_comb begin
    byteSel = mem.mem_rdata[7:0];
    case (offLat)
      2'd1:    byteSel = mem.mem_rdata[15:8];
      2'd2:    byteSel = mem.mem_rdata[23:16];
      2'd3:    byteSel = mem.mem_rdata[31:24];
      default: byteSel = mem.mem_rdata[7:0];
    endcase
    halfSel = offLat[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (opLat)
      OP_LH:   loadExt = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  loadExt = {16'h0, halfSel};
      OP_LB:   loadExt = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  loadExt = {24'h0, byteSel};
      default: loadExt = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (accept) stateNext = S_WAIT;
      S_WAIT:  if (mem.mem_ready || timeoutHit) stateNext = S_DONE;
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    stallM = 1'b0;
    adelM  = 1'b0;
    adesM  = 1'b0;
    if (!rst) begin
      stallM = accept || (state == S_WAIT);
      adelM  = (state == S_IDLE) && memenM && misaligned && !isStore;
      adesM  = (state == S_IDLE) && memenM && misaligned && isStore;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readdataM     <= 32'h0;
      buserrM       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= 32'h0;
      waitCnt       <= '0;
      opLat         <= 3'd0;
      offLat        <= 2'd0;
    end else begin
      buserrM <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          mem.mem_req   <= 1'b1;
          mem.mem_wr    <= isStore;
          mem.mem_addr  <= {aluoutM[31:2], 2'b00};
          mem.mem_wstrb <= storeStrb;
          mem.mem_wdata <= storeData;
          opLat         <= memopM;
          offLat        <= aluoutM[1:0];
          waitCnt       <= '0;
        end
        S_WAIT: begin
          waitCnt <= waitCnt + CNT_W'(1);
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_wr) readdataM <= loadExt;
          end else if (timeoutHit) begin
            mem.mem_req <= 1'b0;
            buserrM     <= 1'b1;
            if (!mem.mem_wr) readdataM <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus
// hand-written timeout, late-ready and mid-access reset sequences.
module tb_mem_access_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic [31:0] expRd;
    logic [3:0]  expStrb;
    logic [31:0] expWd;
    logic        expAdel;
    logic        expAdes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [2:0]  memopM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        stallM, adelM, adesM, buserrM;

  int          nTests = 0;
  int          nFail  = 0;
  logic [31:0] lastRead;
  vec_t        vecs[14];

  mem_access_unit_if memIf ();

  mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memopM     (memopM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .adelM      (adelM),
    .adesM      (adesM),
    .buserrM    (buserrM),
    .mem        (memIf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    logic isSt;
    int   stalls;
    isSt = (v.op >= 3'd5);
    @(negedge clk);
    memenM = 1'b1; memopM = v.op; aluoutM = v.addr; writedataM = v.wd;
    memIf.mem_rdata = v.rd; memIf.mem_ready = 1'b0;
    #1;
    chk({tag, " adelM"}, 32'(adelM), 32'(v.expAdel));
    chk({tag, " adesM"}, 32'(adesM), 32'(v.expAdes));
    if (v.expAdel || v.expAdes) begin
      chk({tag, " stall"}, 32'(stallM), 32'd0);
      @(negedge clk);
      chk({tag, " no req"}, 32'(memIf.mem_req), 32'd0);
      chk({tag, " readdata kept"}, readdataM, lastRead);
      memenM = 1'b0;
      return;
    end
    stalls = int'(stallM);
    @(negedge clk);
    chk({tag, " req"}, 32'(memIf.mem_req), 32'd1);
    chk({tag, " wr"}, 32'(memIf.mem_wr), 32'(isSt));
    chk({tag, " addr"}, memIf.mem_addr, {v.addr[31:2], 2'b00});
    chk({tag, " wstrb"}, 32'(memIf.mem_wstrb), 32'(v.expStrb));
    if (isSt) chk({tag, " wdata"}, memIf.mem_wdata, v.expWd);
    for (int i = 0; i <= v.lat; i++) begin
      memIf.mem_ready = (i == v.lat);
      #1;
      stalls += int'(stallM);
      if (memIf.mem_req !== 1'b1) chk({tag, " req held"}, 32'(memIf.mem_req), 32'd1);
      @(negedge clk);
    end
    chk({tag, " stall cycles"}, 32'(stalls), 32'(v.lat + 2));
    chk({tag, " done stall"}, 32'(stallM), 32'd0);
    chk({tag, " done req"}, 32'(memIf.mem_req), 32'd0);
    chk({tag, " buserr"}, 32'(buserrM), 32'd0);
    if (!isSt) lastRead = v.expRd;
    chk({tag, " readdata"}, readdataM, lastRead);
    memenM = 1'b0; memIf.mem_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{3'd3, 32'h203, 32'h0,        32'h80F07F01, 1, 32'hFFFFFF80, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{3'd4, 32'h203, 32'h0,        32'h80F07F01, 0, 32'h00000080, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{3'd1, 32'h202, 32'h0,        32'h80F07F01, 2, 32'hFFFF80F0, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{3'd2, 32'h200, 32'h0,        32'h80F07F01, 0, 32'h00007F01, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{3'd7, 32'h301, 32'h000000AB, 32'h0,        0, 32'h0,        4'b0010, 32'hABABABAB, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 32'h302, 32'h00001234, 32'h0,        1, 32'h0,        4'b1100, 32'h12341234, 1'b0, 1'b0};
    vecs[7]  = '{3'd5, 32'h404, 32'hCAFEF00D, 32'h0,        0, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 32'h102, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{3'd6, 32'h101, 32'h00005555, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1};
    vecs[10] = '{3'd3, 32'h201, 32'h0,        32'h80F07F01, 0, 32'h0000007F, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[11] = '{3'd4, 32'h202, 32'h0,        32'h80F07F01, 0, 32'h000000F0, 4'b0000, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{3'd0, 32'h103, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
    vecs[13] = '{3'd7, 32'h303, 32'h00000012, 32'h0,        0, 32'h0,        4'b1000, 32'h12121212, 1'b0, 1'b0};

    rst = 1'b1; memenM = 1'b0; memopM = 3'd0; aluoutM = 32'h0; writedataM = 32'h0;
    memIf.mem_rdata = 32'h0; memIf.mem_ready = 1'b0;
    lastRead = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset readdata", readdataM, 32'h0);
    chk("reset req", 32'(memIf.mem_req), 32'd0);
    chk("reset addr", memIf.mem_addr, 32'h0);
    chk("reset stall", 32'(stallM), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle no memen stall", 32'(stallM), 32'd0);

    for (int i = 0; i < 14; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // timeout: ready never arrives, TIMEOUT = 4
    @(negedge clk);
    memenM = 1'b1; memopM = 3'd0; aluoutM = 32'h500; memIf.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("to wait%0d req", i), 32'(memIf.mem_req), 32'd1);
      chk($sformatf("to wait%0d stall", i), 32'(stallM), 32'd1);
      chk($sformatf("to wait%0d buserr", i), 32'(buserrM), 32'd0);
    end
    @(negedge clk);
    chk("to buserr", 32'(buserrM), 32'd1);
    chk("to req", 32'(memIf.mem_req), 32'd0);
    chk("to readdata", readdataM, 32'h0);
    chk("to stall", 32'(stallM), 32'd0);
    lastRead = 32'h0;
    memenM = 1'b0;
    @(negedge clk);
    chk("to buserr pulse", 32'(buserrM), 32'd0);

    // ready on the 4th WAIT cycle beats the timeout
    runVec('{3'd0, 32'h600, 32'h0, 32'h13579BDF, 3, 32'h13579BDF, 4'b0000, 32'h0, 1'b0, 1'b0}, "late");

    // reset in the 2nd WAIT cycle, with a stale ready present
    @(negedge clk);
    memenM = 1'b1; memopM = 3'd7; aluoutM = 32'h702; writedataM = 32'hEE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; memIf.mem_ready = 1'b1; memIf.mem_rdata = 32'hBADBAD00;
    #1;
    chk("rst stall forced", 32'(stallM), 32'd0);
    @(negedge clk);
    chk("rst req", 32'(memIf.mem_req), 32'd0);
    chk("rst wr", 32'(memIf.mem_wr), 32'd0);
    chk("rst addr", memIf.mem_addr, 32'h0);
    chk("rst wstrb", 32'(memIf.mem_wstrb), 32'd0);
    chk("rst wdata", memIf.mem_wdata, 32'h0);
    chk("rst buserr", 32'(buserrM), 32'd0);
    rst = 1'b0; memenM = 1'b0; memIf.mem_ready = 1'b0;
    @(negedge clk);
    chk("post rst readdata", readdataM, 32'h0);
    lastRead = 32'h0;
    runVec('{3'd0, 32'h104, 32'h0, 32'h2468ACE0, 0, 32'h2468ACE0, 4'b0000, 32'h0, 1'b0, 1'b0}, "post rst");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
